// File: rtl/music_player_if.sv
// rtl/music_player_if.sv - score-lookup and control bundle between a player and its host
interface music_player_if;
    logic        play;
    logic        loop;
    logic [9:0]  number;
    logic [19:0] note;
    logic [4:0]  duration;
    logic        speaker;
    logic        busy;
    logic        done;

    modport slave (
        input  play, loop, note, duration,
        output number, speaker, busy, done
    );

    modport master (
        output play, loop, note, duration,
        input  number, speaker, busy, done
    );
endinterface

// File: rtl/music_player.sv
// rtl/music_player.sv - steps through a score table, playing each note as a square wave
module music_player #(
    parameter int EIGHTH_TICKS = 12500000,
    parameter int LAST_INDEX   = 44
) (
    input  logic          clk,
    input  logic          reset,
    music_player_if.slave bus
);
    localparam int             TW       = $clog2(EIGHTH_TICKS);
    localparam logic [TW-1:0]  TICK_MAX = TW'(EIGHTH_TICKS - 1);
    localparam logic [9:0]     LAST     = 10'(LAST_INDEX);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tick;
    logic [19:0]   r_tone;
    logic [19:0]   r_note;
    logic [4:0]    r_dur;
    logic [9:0]    r_number;
    logic          r_speaker;
    logic          r_busy;
    logic          r_done;

    logic w_run, w_tick_wrap, w_note_end, w_tone_on, w_tone_top, w_last;

    assign w_run       = (r_state == PLAY) && bus.play;
    assign w_tick_wrap = (r_tick == TICK_MAX);
    assign w_note_end  = w_run && w_tick_wrap && (r_dur == 5'd1);
    assign w_tone_on   = (r_note >= 20'd2);
    assign w_tone_top  = (r_tone == r_note - 20'd1);
    assign w_last      = (r_number == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (bus.play) w_state_next = LOAD;
            LOAD: w_state_next = PLAY;
            PLAY: if (w_note_end) w_state_next = (w_last && !bus.loop) ? DONE : LOAD;
            DONE: if (!bus.play) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick    <= '0;
            r_tone    <= '0;
            r_note    <= '0;
            r_dur     <= '0;
            r_number  <= '0;
            r_speaker <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Status flags track the state being entered so they line up with it.
            r_busy <= (w_state_next == LOAD) || (w_state_next == PLAY);
            r_done <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    r_number  <= '0;
                    r_speaker <= 1'b0;
                end
                LOAD: begin
                    r_note    <= bus.note;
                    r_dur     <= (bus.duration == 5'd0) ? 5'd1 : bus.duration;
                    r_tick    <= '0;
                    r_tone    <= '0;
                    r_speaker <= 1'b0;
                end
                PLAY: begin
                    if (!bus.play) begin
                        r_speaker <= 1'b0;
                    end else begin
                        r_tick <= w_tick_wrap ? '0 : r_tick + TW'(1);
                        if (w_tick_wrap && (r_dur != 5'd1))
                            r_dur <= r_dur - 5'd1;
                        if (w_note_end) begin
                            r_speaker <= 1'b0;
                            if (!w_last)      r_number <= r_number + 10'd1;
                            else if (bus.loop) r_number <= '0;
                        end else if (w_tone_on) begin
                            if (w_tone_top) begin
                                r_tone    <= '0;
                                r_speaker <= ~r_speaker;
                            end else begin
                                r_tone <= r_tone + 20'd1;
                            end
                        end else begin
                            r_speaker <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_speaker <= 1'b0;
                    if (!bus.play) r_number <= '0;
                end
                default: r_speaker <= 1'b0;
            endcase
        end
    end

    assign bus.number  = r_number;
    assign bus.speaker = r_speaker;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_music_player.sv
// tb/tb_music_player.sv - directed bench for music_player with a three-entry score stub
module tb_music_player;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_seen;

    music_player_if bus ();

    music_player #(.EIGHTH_TICKS(4), .LAST_INDEX(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.note     = 20'd0;
        bus.duration = 5'd0;
        case (bus.number)
            10'd0: begin bus.note = 20'd3; bus.duration = 5'd2; end
            10'd1: begin bus.note = 20'd1; bus.duration = 5'd1; end
            10'd2: begin bus.note = 20'd2; bus.duration = 5'd0; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.play = 1'b0;
        bus.loop = 1'b0;
        cyc(2);
        check("rst_number", 32'(bus.number), 0);
        check("rst_speaker", 32'(bus.speaker), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        reset = 1'b0;
        cyc(3);
        check("idle_hold_busy", 32'(bus.busy), 0);

        // Single pass, loop=0. Edge count k follows the negedge where play rises.
        bus.play = 1'b1;
        cyc(1);
        check("load_busy", 32'(bus.busy), 1);
        check("load_number", 32'(bus.number), 0);
        cyc(1);
        check("n0_spk_e2", 32'(bus.speaker), 0);
        cyc(3);
        check("n0_spk_e5", 32'(bus.speaker), 1);
        cyc(2);
        check("n0_spk_e7", 32'(bus.speaker), 1);
        cyc(1);
        check("n0_spk_e8", 32'(bus.speaker), 0);
        cyc(1);
        check("n0_num_e9", 32'(bus.number), 0);
        cyc(1);
        check("n0_num_e10", 32'(bus.number), 1);
        cyc(4);
        check("n1_silent", 32'(bus.speaker), 0);
        check("n1_num_e14", 32'(bus.number), 1);
        cyc(1);
        check("n1_num_e15", 32'(bus.number), 2);
        cyc(3);
        check("n2_spk_e18", 32'(bus.speaker), 1);
        cyc(1);
        check("n2_busy_e19", 32'(bus.busy), 1);
        check("n2_done_e19", 32'(bus.done), 0);
        cyc(1);
        check("end_done", 32'(bus.done), 1);
        check("end_busy", 32'(bus.busy), 0);
        check("end_number", 32'(bus.number), 2);
        check("end_speaker", 32'(bus.speaker), 0);
        cyc(2);
        check("done_hold", 32'(bus.done), 1);
        bus.play = 1'b0;
        cyc(1);
        check("idle_done", 32'(bus.done), 0);
        check("idle_number", 32'(bus.number), 0);

        // Looping pass with a 5-cycle pause during the replayed first note.
        bus.loop = 1'b1;
        bus.play = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.done) done_seen++;
        end
        check("loop_no_done", 32'(done_seen), 0);
        check("loop_number", 32'(bus.number), 0);
        check("loop_busy", 32'(bus.busy), 1);
        cyc(4);
        check("loop_spk_e24", 32'(bus.speaker), 1);
        bus.play = 1'b0;
        cyc(1);
        check("pause_spk", 32'(bus.speaker), 0);
        check("pause_busy", 32'(bus.busy), 1);
        cyc(4);
        check("pause_num_e29", 32'(bus.number), 0);
        bus.play = 1'b1;
        cyc(3);
        check("resume_spk_e32", 32'(bus.speaker), 1);
        cyc(1);
        check("resume_num_e33", 32'(bus.number), 0);
        cyc(1);
        check("resume_num_e34", 32'(bus.number), 1);
        cyc(2);
        check("pre_rst_busy", 32'(bus.busy), 1);

        // Asynchronous reset between edges mid-note.
        #2;
        reset = 1'b1;
        bus.play = 1'b0;
        #1;
        check("async_number", 32'(bus.number), 0);
        check("async_busy", 32'(bus.busy), 0);
        check("async_speaker", 32'(bus.speaker), 0);
        check("async_done", 32'(bus.done), 0);
        cyc(1);
        reset = 1'b0;
        cyc(3);
        check("post_rst_idle", 32'(bus.busy), 0);
        bus.play = 1'b1;
        cyc(1);
        check("post_rst_load", 32'(bus.busy), 1);
        check("post_rst_number", 32'(bus.number), 0);
        cyc(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameter EIGHTH_TICKS, default 12500000: clock cycles per eighth-note unit (0.125 s at 100 MHz); legal range >= 2.
REQ-002 Parameter LAST_INDEX, default 44: final score index; legal range 0..1023.
REQ-003 Port clk  input  1: single system clock, rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port play  input  1: level enable; high = run or resume, low = pause or stop.
REQ-006 Port loop  input  1: on completion of LAST_INDEX, restart at index 0 instead of finishing.
REQ-007 Port number  output  10: score index driven to the combinational score lookup.
REQ-008 Port note  input  20: tone half-period in clk cycles, returned by the lookup for number; values 0 and 1 mean silence.
REQ-009 Port duration  input  5: note length in eighth-note units, returned by the lookup for number.
REQ-010 Port speaker  output  1: square-wave audio output.
REQ-011 Port busy  output  1: high in LOAD and PLAY states.
REQ-012 Port done  output  1: high in DONE state.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, PLAY and DONE; all outputs SHALL be registered.
REQ-014 IDLE: number=0, speaker=0; on play=1 the next state SHALL be LOAD.
REQ-015 LOAD (exactly 1 cycle): latch note into note_r and duration into dur_r, with duration=0 latched as 1; clear tick and tone counters; next state SHALL be PLAY.
REQ-016 PLAY: the tick counter SHALL count 0..EIGHTH_TICKS-1 and wrap; dur_r SHALL decrement on each wrap; the note SHALL end on the wrap at which dur_r==1.
REQ-017 Note length SHALL be exactly dur_r*EIGHTH_TICKS cycles of PLAY with play=1, plus 1 LOAD cycle per note.
REQ-018 Tone: if note_r>=2, the tone counter SHALL count 0..note_r-1 and toggle speaker on reaching note_r-1, giving a period of 2*note_r cycles; if note_r<=1, speaker SHALL be held 0.
REQ-019 At note end with number<LAST_INDEX: number<=number+1, next state LOAD.
REQ-020 At note end with number==LAST_INDEX: if loop=1, number<=0 and next state LOAD; else next state DONE with number held.
REQ-021 Speaker SHALL be forced to 0 on every LOAD entry so each note starts at phase 0.
REQ-022 play=0 in PLAY: pause; tick, tone and duration counters hold, speaker forced 0, state remains PLAY, busy stays 1; play=1 resumes counting from the held values.
REQ-023 play=0 in LOAD: LOAD still completes into PLAY, then pauses per REQ-022.
REQ-024 DONE: speaker=0, number held; play=0 -> IDLE (number<=0); play=1 stays in DONE.
REQ-025 loop sampled only at the note-end cycle of LAST_INDEX; changes elsewhere have no effect.
REQ-026 Counter widths SHALL cover EIGHTH_TICKS-1 and 2^20-1 without overflow; number SHALL never exceed LAST_INDEX.

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, force state IDLE, number=0, speaker=0, busy=0, done=0, and clear all counters and latches.
REQ-028 Reset mid-note SHALL abandon the note; after release the block SHALL stay in IDLE until play=1.

Verification (EIGHTH_TICKS=4, LAST_INDEX=2, behavioural lookup stub)
REQ-029 Stub idx0={note 3, dur 2}; play=1 -> LOAD 1 cycle; PLAY lasts 8 cycles; speaker toggles every 3 cycles; number becomes 1.
REQ-030 Stub idx1={note 1, dur 1} -> speaker stays 0 for 4 PLAY cycles; idx2 dur=0 -> plays 4 cycles.
REQ-031 loop=0 -> after idx2, done=1, busy=0, number=2; drop play -> IDLE, number=0.
REQ-032 loop=1 -> after idx2, number=0, LOAD follows; done never asserts.
REQ-033 play=0 for 5 cycles mid-note -> speaker=0, counters frozen; total PLAY duration grows by exactly 5 cycles.
REQ-034 reset pulse asserted between clock edges mid-PLAY -> outputs go to reset values before the next edge; IDLE held until play=1.
